// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: bus widths, master FSM states, response codes.
// Used by the master bridge and by the RAM slave on the same bus.
package axi4_lite_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_WRITE   = 6'b000010,
        ST_WAIT_B  = 6'b000100,
        ST_READ_AR = 6'b001000,
        ST_WAIT_R  = 6'b010000,
        ST_RESP    = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/AXI_BUS.sv
// AXI4-Lite bus bundle shared by the master bridge and the RAM slave.
// Word addressed; responses carried as raw 2-bit codes.
interface AXI_BUS #(
    parameter int DATA_WIDTH = axi4_lite_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = axi4_lite_pkg::DEFAULT_ADDR_WIDTH
) ();
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport Master (
        output aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport Slave (
        input  aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Request/response port to AXI4-Lite master bridge, one transaction in flight.
// Latency: first AXI valid 1 cycle after accept; rsp_valid 3 cycles after accept on a zero-wait slave.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    AXI_BUS.Master                amba_master
);

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_fire;
    logic   w_fire;

    assign aw_fire   = amba_master.aw_valid && amba_master.aw_ready;
    assign w_fire    = amba_master.w_valid && amba_master.w_ready;
    assign req_ready = (state == ST_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            aw_done              <= 1'b0;
            w_done               <= 1'b0;
            amba_master.aw_valid <= 1'b0;
            amba_master.aw_addr  <= '0;
            amba_master.w_valid  <= 1'b0;
            amba_master.w_data   <= '0;
            amba_master.b_ready  <= 1'b0;
            amba_master.ar_valid <= 1'b0;
            amba_master.ar_addr  <= '0;
            amba_master.r_ready  <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_write            <= 1'b0;
            rsp_rdata            <= '0;
            rsp_resp             <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_write) begin
                            amba_master.aw_addr  <= req_addr;
                            amba_master.w_data   <= req_wdata;
                            amba_master.aw_valid <= 1'b1;
                            amba_master.w_valid  <= 1'b1;
                            aw_done              <= 1'b0;
                            w_done               <= 1'b0;
                            state                <= ST_WRITE;
                        end else begin
                            amba_master.ar_addr  <= req_addr;
                            amba_master.ar_valid <= 1'b1;
                            state                <= ST_READ_AR;
                        end
                    end
                end

                // AW and W complete independently; the slave may take either first.
                ST_WRITE: begin
                    if (aw_fire) begin
                        amba_master.aw_valid <= 1'b0;
                        aw_done              <= 1'b1;
                    end
                    if (w_fire) begin
                        amba_master.w_valid <= 1'b0;
                        w_done              <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        amba_master.b_ready <= 1'b1;
                        state               <= ST_WAIT_B;
                    end
                end

                ST_WAIT_B: begin
                    if (amba_master.b_valid) begin
                        amba_master.b_ready <= 1'b0;
                        rsp_resp            <= amba_master.b_resp;
                        rsp_rdata           <= '0;
                        rsp_write           <= 1'b1;
                        rsp_valid           <= 1'b1;
                        state               <= ST_RESP;
                    end
                end

                ST_READ_AR: begin
                    if (amba_master.ar_ready) begin
                        amba_master.ar_valid <= 1'b0;
                        amba_master.r_ready  <= 1'b1;
                        state                <= ST_WAIT_R;
                    end
                end

                ST_WAIT_R: begin
                    if (amba_master.r_valid) begin
                        amba_master.r_ready <= 1'b0;
                        rsp_rdata           <= amba_master.r_data;
                        rsp_resp            <= amba_master.r_resp;
                        rsp_write           <= 1'b0;
                        rsp_valid           <= 1'b1;
                        state               <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
